ifu_fetch: RTL and testbench

Instruction fetch unit that sits directly upstream of the IF/ID buffer. It owns the PC and issues in-order requests on the instruction bus (req/gnt, then rvalid). Returned instructions are held in a small prefetch FIFO and presented to IF/ID, which can stall them. On a pipeline redirect (jump/branch/flush) the unit drops stale in-flight responses and restarts fetch at the target.

---
 rtl/ifu_fetch_pkg.sv | 7 +
 rtl/ifu_fifo.sv | 46 ++++
 rtl/ifu_fetch.sv | 82 ++++++++
 tb/tb_ifu_fetch.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_fetch_pkg.sv
// Shared RV32 fetch constants used by the fetch unit and its prefetch FIFO.
package ifu_fetch_pkg;
  localparam int          RV32_ADDR_WIDTH = 32;
  localparam int          RV32_INST_WIDTH = 32;
  localparam logic [31:0] RST_INST_ADDR   = 32'h0000_0000;
  localparam logic [31:0] INST_NOP        = 32'h0000_0013;
endpackage

// File: rtl/ifu_fifo.sv
// Synchronous prefetch FIFO. Same-cycle push/pop is legal even when full,
// and clear wins over both.
module ifu_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       clear,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               wr_ptr, rd_ptr;
  logic                        do_pop;

  assign do_pop = pop && (count != '0);
  assign head   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: it is only observed through a non-zero count.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, issues credit-limited in-order bus
// requests, buffers responses and drops stale ones after a redirect.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter int                        ADDR_WIDTH = RV32_ADDR_WIDTH,
  parameter int                        INST_WIDTH = RV32_INST_WIDTH,
  parameter logic [ADDR_WIDTH-1:0]     RST_ADDR   = RST_INST_ADDR,
  parameter int                        FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  jump_en_i,
  input  logic [ADDR_WIDTH-1:0] jump_addr_i,
  input  logic                  hold_i,
  output logic                  ibus_req_o,
  output logic [ADDR_WIDTH-1:0] ibus_addr_o,
  input  logic                  ibus_gnt_i,
  input  logic                  ibus_rvalid_i,
  input  logic [INST_WIDTH-1:0] ibus_rdata_i,
  output logic                  inst_valid_o,
  output logic [ADDR_WIDTH-1:0] inst_addr_o,
  output logic [INST_WIDTH-1:0] inst_o
);
  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam int EW = ADDR_WIDTH + INST_WIDTH;

  logic [ADDR_WIDTH-1:0] pc, resp_pc, jump_tgt;
  logic [CW-1:0]         outstanding, discard, fifo_count;
  logic [CW:0]           in_use;
  logic                  issue, keep, push, pop, inst_valid;
  logic [EW-1:0]         head;

  assign jump_tgt = {jump_addr_i[ADDR_WIDTH-1:2], 2'b00};

  // Credits cover both in-flight and buffered entries, so the FIFO can never overflow.
  assign in_use      = {1'b0, outstanding} + {1'b0, fifo_count};
  assign ibus_req_o  = rst_n && !jump_en_i && (in_use < (CW+1)'(FIFO_DEPTH));
  assign ibus_addr_o = pc;
  assign issue       = ibus_req_o && ibus_gnt_i;

  assign keep       = ibus_rvalid_i && (discard == '0);
  assign push       = keep && !jump_en_i;
  assign inst_valid = (fifo_count != '0);
  assign pop        = inst_valid && !hold_i && !jump_en_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RST_ADDR;
      resp_pc     <= RST_ADDR;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding + CW'(issue) - CW'(ibus_rvalid_i);
      if (jump_en_i) begin
        pc      <= jump_tgt;
        resp_pc <= jump_tgt;
        // A response landing in the jump cycle is already stale and is not counted.
        discard <= outstanding - CW'(ibus_rvalid_i);
      end else begin
        if (issue) pc <= pc + ADDR_WIDTH'(4);
        if (keep)  resp_pc <= resp_pc + ADDR_WIDTH'(4);
        if (ibus_rvalid_i && (discard != '0)) discard <= discard - CW'(1);
      end
    end
  end

  ifu_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({resp_pc, ibus_rdata_i}),
    .pop       (pop),
    .clear     (jump_en_i),
    .head      (head),
    .count     (fifo_count)
  );

  assign inst_valid_o = inst_valid;
  assign inst_addr_o  = inst_valid ? head[EW-1:INST_WIDTH] : RST_ADDR;
  assign inst_o       = inst_valid ? head[INST_WIDTH-1:0]  : INST_WIDTH'(INST_NOP);
endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: bus/memory model plus an epoch-tagged scoreboard of
// the expected presented stream, with directed tables and random traffic.
module tb_ifu_fetch;
  import ifu_fetch_pkg::*;
  localparam int DEPTH = 2;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        jump_en_i = 1'b0, hold_i = 1'b0, ibus_gnt_i = 1'b0, ibus_rvalid_i = 1'b0;
  logic [31:0] jump_addr_i = '0, ibus_rdata_i = '0;
  logic        ibus_req_o, inst_valid_o;
  logic [31:0] ibus_addr_o, inst_addr_o, inst_o;

  ifu_fetch #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i),
    .hold_i(hold_i), .ibus_req_o(ibus_req_o), .ibus_addr_o(ibus_addr_o),
    .ibus_gnt_i(ibus_gnt_i), .ibus_rvalid_i(ibus_rvalid_i), .ibus_rdata_i(ibus_rdata_i),
    .inst_valid_o(inst_valid_o), .inst_addr_o(inst_addr_o), .inst_o(inst_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int epoch; int ready; } bus_t;
  typedef struct { bit hold; bit req; logic [31:0] addr; bit valid; logic [31:0] iaddr; } vec_t;

  bus_t        busq[$];   // requests accepted by the memory, oldest first
  logic [31:0] fifoq[$];  // addresses the DUT should currently be presenting/buffering
  int          epoch, cyc, lat_fix, checks, errors;
  bit          gnt_rand;
  logic [31:0] issue_pc;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return a + 32'h100;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
    end
  endtask

  task automatic model_check();
    logic exp_req;
    exp_req = !jump_en_i && (busq.size() + fifoq.size() < DEPTH);
    chk("req", ibus_req_o, exp_req);
    if (exp_req) chk("addr", ibus_addr_o, issue_pc);
    chk("valid", inst_valid_o, fifoq.size() > 0);
    if (fifoq.size() > 0) begin
      chk("iaddr", inst_addr_o, fifoq[0]);
      chk("inst", inst_o, rom(fifoq[0]));
    end else chk("nop", inst_o, INST_NOP);
    chk("credit", busq.size() <= DEPTH, 1);
  endtask

  // Called at posedge+1 with hold/jump already set; returns at the next posedge+1.
  task automatic cycle();
    bus_t r;
    bit   hs, popq;
    int   lat;
    ibus_gnt_i = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    if (busq.size() > 0 && busq[0].ready <= cyc) begin
      ibus_rvalid_i = 1'b1;
      ibus_rdata_i  = rom(busq[0].addr);
    end else begin
      ibus_rvalid_i = 1'b0;
      ibus_rdata_i  = $urandom;
    end
    #1;
    model_check();
    lat  = (lat_fix < 0) ? $urandom_range(0, 4) : lat_fix;
    hs   = ibus_req_o && ibus_gnt_i;
    popq = (fifoq.size() > 0) && !hold_i;
    if (ibus_rvalid_i) r = busq.pop_front();
    if (jump_en_i) begin
      fifoq.delete();
      epoch++;
      issue_pc = jump_addr_i & ~32'h3;
    end else begin
      if (popq) fifoq.delete(0);
      if (ibus_rvalid_i && r.epoch == epoch) fifoq.push_back(r.addr);
    end
    if (hs) begin
      busq.push_back('{ibus_addr_o, epoch, cyc + 1 + lat});
      issue_pc += 32'd4;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic wait_valid(input string name, input int maxc);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      if (inst_valid_o) begin ok = 1'b1; break; end
      cycle();
    end
    chk(name, ok, 1);
  endtask

  task automatic jump_to(input logic [31:0] a);
    jump_en_i   = 1'b1;
    jump_addr_i = a;
    cycle();
    jump_en_i   = 1'b0;
  endtask

  task automatic do_reset();
    ibus_gnt_i = 1'b0; ibus_rvalid_i = 1'b0; jump_en_i = 1'b0; hold_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_req", ibus_req_o, 0);
    chk("rst_valid", inst_valid_o, 0);
    chk("rst_iaddr", inst_addr_o, RST_INST_ADDR);
    chk("rst_inst", inst_o, INST_NOP);
    @(posedge clk); @(posedge clk);
    cyc += 2;
    #1 rst_n = 1'b1;
    busq.delete();
    fifoq.delete();
    issue_pc = RST_INST_ADDR;
    epoch++;
  endtask

  initial begin
    vec_t        tv[7];
    logic [31:0] held;
    logic [31:0] wrap_exp[3];
    checks = 0; errors = 0; epoch = 0; cyc = 0;
    gnt_rand = 1'b0; lat_fix = 0; issue_pc = RST_INST_ADDR;

    // gnt always, 1-cycle rvalid: credit limit of 2 throttles issue
    tv[0] = '{0, 1, 32'h0,  0, 32'h0};
    tv[1] = '{0, 1, 32'h4,  0, 32'h0};
    tv[2] = '{0, 0, 32'h0,  1, 32'h0};
    tv[3] = '{0, 1, 32'h8,  1, 32'h4};
    tv[4] = '{0, 1, 32'hc,  0, 32'h0};
    tv[5] = '{0, 0, 32'h0,  1, 32'h8};
    tv[6] = '{0, 1, 32'h10, 1, 32'hc};
    wrap_exp[0] = 32'hFFFF_FFF8; wrap_exp[1] = 32'hFFFF_FFFC; wrap_exp[2] = 32'h0;

    do_reset();

    for (int i = 0; i < 7; i++) begin
      hold_i = tv[i].hold;
      #1;
      chk("t1_req", ibus_req_o, tv[i].req);
      if (tv[i].req) chk("t1_addr", ibus_addr_o, tv[i].addr);
      chk("t1_valid", inst_valid_o, tv[i].valid);
      if (tv[i].valid) begin
        chk("t1_iaddr", inst_addr_o, tv[i].iaddr);
        chk("t1_inst", inst_o, tv[i].iaddr + 32'h100);
      end else chk("t1_nop", inst_o, INST_NOP);
      cycle();
    end

    // Hold mid-stream: output frozen, credits run out
    wait_valid("t2_wait", 10);
    held   = inst_addr_o;
    hold_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("t2_hold_addr", inst_addr_o, held);
      chk("t2_hold_valid", inst_valid_o, 1);
      cycle();
    end
    chk("t2_req_drop", ibus_req_o, 0);
    hold_i = 1'b0;
    for (int i = 0; i < 10; i++) cycle();

    // Jump with two requests in flight
    lat_fix = 3;
    for (int i = 0; i < 20; i++) begin
      if (busq.size() == 2) break;
      cycle();
    end
    chk("t3_inflight", busq.size(), 2);
    jump_en_i = 1'b1; jump_addr_i = 32'h200;
    #1 chk("t3_noreq", ibus_req_o, 0);
    cycle();
    jump_en_i = 1'b0;
    wait_valid("t3_wait", 30);
    chk("t3_addr", inst_addr_o, 32'h200);
    chk("t3_inst", inst_o, 32'h300);

    // Jump in the same cycle as a response
    lat_fix = 0;
    for (int i = 0; i < 20; i++) begin
      if (busq.size() > 0 && busq[0].ready <= cyc) break;
      cycle();
    end
    chk("t4_coincide", busq.size() > 0 && busq[0].ready <= cyc, 1);
    jump_to(32'h300);
    wait_valid("t4a_wait", 20);
    chk("t4a_addr", inst_addr_o, 32'h300);

    // Jump while held: buffer flushed regardless of hold
    hold_i = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    chk("t4b_full", inst_valid_o, 1);
    jump_to(32'h400);
    chk("t4b_flush_valid", inst_valid_o, 0);
    chk("t4b_flush_nop", inst_o, INST_NOP);
    hold_i = 1'b0;
    wait_valid("t4b_wait", 20);
    chk("t4b_addr", inst_addr_o, 32'h400);

    // Misaligned target and PC wrap
    jump_to(32'h0000_0106);
    wait_valid("t5_wait", 20);
    chk("t5_addr", inst_addr_o, 32'h104);
    jump_to(32'hFFFF_FFF8);
    for (int k = 0; k < 3; k++) begin
      wait_valid("t5_wrap_wait", 10);
      chk("t5_wrap_addr", inst_addr_o, wrap_exp[k]);
      cycle();
    end

    // Random traffic with a mid-run asynchronous reset
    gnt_rand = 1'b1; lat_fix = -1;
    for (int n = 0; n < 10000; n++) begin
      if (n == 5000) do_reset();
      hold_i      = ($urandom_range(0, 99) < 30);
      jump_en_i   = ($urandom_range(0, 99) < 3);
      jump_addr_i = $urandom;
      cycle();
    end
    jump_en_i = 1'b0; hold_i = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
